// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between a data producer and the seven-segment scan
// driver: the producer writes the display word and masks, the driver
// returns the anode/segment pins and scan status.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    localparam int IDX_W = $clog2(DIGITS);

    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic                  lz_en;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;
    logic [IDX_W-1:0]      scan_idx;
    logic                  frame_tick;

    // Producer side: supplies what to show, observes the scan.
    modport master (
        output load, data, dp, blank, lz_en,
        input  an, seg, scan_idx, frame_tick
    );

    // Driver side: consumes the display word, drives the pins.
    modport slave (
        input  load, data, dp, blank, lz_en,
        output an, seg, scan_idx, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. A divider sets the
// slot length; each slot starts with a dead time (all anodes off) to avoid
// ghosting, then lights one digit. All pin outputs are registered.
module seg7_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_CYCLES  = 100000,
    parameter int GHOST_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   disp_if
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int DIV_W = $clog2(SCAN_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_CYCLES - 1);
    localparam logic [DIV_W-1:0] GHOST_LIM = DIV_W'(GHOST_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam bit               HAS_GHOST = (GHOST_CYCLES > 0);

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // Scan state
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Shadow copy of the display word and masks
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;

    // Registered pin outputs
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic                frame_tick_q, frame_tick_d;

    // Per-digit views of the (next) shadow word. The output stage reads the
    // next-state shadow so a load shows up on the very next output update,
    // including when it coincides with a slot change.
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   upper_zero;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = shadow_data_d[4*gi +: 4];
            // Digit gi and everything to its left are zero.
            assign upper_zero[gi] = (shadow_data_d[4*DIGITS-1 : 4*gi] == '0);
        end
    endgenerate

    logic terminal;
    logic ghost;
    logic dark;

    // Next-state logic for divider, digit index, shadows and pin outputs.
    always_comb begin
        shadow_data_d  = disp_if.load ? disp_if.data  : shadow_data_q;
        shadow_dp_d    = disp_if.load ? disp_if.dp    : shadow_dp_q;
        shadow_blank_d = disp_if.load ? disp_if.blank : shadow_blank_q;

        terminal = (div_q == DIV_LAST);
        div_d    = terminal ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        ghost = HAS_GHOST && (div_q < GHOST_LIM);
        // Digit 0 is exempt from suppression so an all-zero word still reads "0".
        dark  = shadow_blank_d[idx_q] ||
                (disp_if.lz_en && (idx_q != '0) && upper_zero[idx_q]);

        if (ghost || dark) begin
            an_d  = '1;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = {~shadow_dp_d[idx_q], hex_to_seg(nib[idx_q])};
        end

        scan_idx_d   = idx_q;
        frame_tick_d = terminal && (idx_q == IDX_LAST);
    end

    // State and output registers; reset wins over everything, including load.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q          <= '0;
            idx_q          <= '0;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            an_q           <= '1;
            seg_q          <= 8'hFF;
            scan_idx_q     <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            div_q          <= div_d;
            idx_q          <= idx_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            scan_idx_q     <= scan_idx_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign disp_if.an         = an_q;
    assign disp_if.seg        = seg_q;
    assign disp_if.scan_idx   = scan_idx_q;
    assign disp_if.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots and a
// 1-cycle dead time. Expected patterns are written out by hand from the
// decode table.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) dif ();

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .SCAN_CYCLES (4),
        .GHOST_CYCLES(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .disp_if(dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"},         32'(dif.an),         32'hF);
        check({tag, " seg"},        32'(dif.seg),        32'hFF);
        check({tag, " scan_idx"},   32'(dif.scan_idx),   32'h0);
        check({tag, " frame_tick"}, 32'(dif.frame_tick), 32'h0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        @(negedge clk);
        dif.data  = d;
        dif.dp    = p;
        dif.blank = b;
        dif.load  = 1'b1;
        @(negedge clk);
        dif.load  = 1'b0;
        $display("load data=%04h dp=%b blank=%b", d, p, b);
    endtask

    // Returns on the sample where frame_tick is high (bounded wait).
    task automatic sync_frame(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (dif.frame_tick !== 1'b1 && i < 40);
        check({tag, " sync frame_tick"}, 32'(dif.frame_tick), 32'h1);
    endtask

    // One full frame: for each digit a dark cycle, then three lit cycles.
    task automatic check_frame(input string tag, input logic [15:0] ean, input logic [31:0] eseg);
        logic [3:0] a_exp;
        logic [7:0] s_exp;
        int         d;
        sync_frame(tag);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = k / 4;
            if (k % 4 == 0) begin
                a_exp = 4'hF;
                s_exp = 8'hFF;
            end else begin
                a_exp = ean[4*d +: 4];
                s_exp = eseg[8*d +: 8];
            end
            check($sformatf("%s k=%0d an", tag, k),  32'(dif.an),  32'(a_exp));
            check($sformatf("%s k=%0d seg", tag, k), 32'(dif.seg), 32'(s_exp));
            check($sformatf("%s k=%0d idx", tag, k), 32'(dif.scan_idx), 32'(d));
            check($sformatf("%s k=%0d tick", tag, k), 32'(dif.frame_tick), 32'(k == 15));
        end
        $display("frame %s an=%04h seg=%08h checked", tag, ean, eseg);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        dif.load   = 1'b0;
        dif.data   = '0;
        dif.dp     = '0;
        dif.blank  = '0;
        dif.lz_en  = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("reset c%0d", i));
        end
        rst = 1'b0;
        @(negedge clk);
        check("post-reset dead an", 32'(dif.an), 32'hF);
        @(negedge clk);
        check("first lit an",  32'(dif.an),  32'hE);
        check("first lit seg", 32'(dif.seg), 32'hC0);

        // Scan order and decode
        do_load(16'h1234, 4'b0000, 4'b0000);
        check_frame("h1234", 16'h7BDE, 32'hF9A4B099);

        // Leading-zero suppression
        do_load(16'h0050, 4'b0000, 4'b0000);
        dif.lz_en = 1'b1;
        check_frame("lz_on", 16'hFFDE, 32'hFFFF92C0);
        dif.lz_en = 1'b0;
        check_frame("lz_off", 16'h7BDE, 32'hC0C092C0);

        // Decimal-point and blank masks
        do_load(16'h0050, 4'b0010, 4'b1000);
        check_frame("masks", 16'hFBDE, 32'hFFC012C0);

        // Load while digit 2 is lit
        sync_frame("midload");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 9) begin
                check("midload old an",  32'(dif.an),  32'hB);
                check("midload old seg", 32'(dif.seg), 32'hC0);
                dif.data  = 16'hFFFF;
                dif.dp    = 4'b0000;
                dif.blank = 4'b0000;
                dif.load  = 1'b1;
            end else if (k == 10) begin
                dif.load = 1'b0;
                check("midload new an",  32'(dif.an),  32'hB);
                check("midload new seg", 32'(dif.seg), 32'h8E);
            end else if (k == 11) begin
                check("midload hold seg", 32'(dif.seg), 32'h8E);
            end
        end
        $display("load data=ffff mid-slot on digit 2");
        check_frame("hFFFF", 16'h7BDE, 32'h8E8E8E8E);

        // Reset during digit 2, with a competing load
        sync_frame("midrst");
        for (int k = 0; k < 10; k++) @(negedge clk);
        rst       = 1'b1;
        dif.data  = 16'h1234;
        dif.load  = 1'b1;
        @(negedge clk);
        dif.load  = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst hold");
        rst = 1'b0;
        @(negedge clk);
        check("midrst dead an", 32'(dif.an), 32'hF);
        @(negedge clk);
        check("midrst restart an",  32'(dif.an),       32'hE);
        check("midrst restart seg", 32'(dif.seg),      32'hC0);
        check("midrst restart idx", 32'(dif.scan_idx), 32'h0);
        $display("reset mid-scan, restart at digit 0");

        // Cleared shadow: digit 0 survives suppression, then all zeros
        dif.lz_en = 1'b1;
        check_frame("zero_lz", 16'hFFFE, 32'hFFFFFFC0);
        dif.lz_en = 1'b0;
        check_frame("zero", 16'h7BDE, 32'hC0C0C0C0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
